// File: rtl/window_buffer.sv
// window_buffer: raster pixel stream to a packed 5x5 neighbourhood for median.
// Optional feature macro WINDOW_SOF_EN adds in_sof to resynchronise the frame position.
module window_buffer #(
   parameter int DATA_WIDTH  = 8,
   parameter int IMG_W       = 64,
   parameter int IMG_H       = 64,
   parameter int WINDOW_S    = 25,
   parameter int WINDOW_BITS = 200
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
`ifdef WINDOW_SOF_EN
   input  logic                   in_sof,
`endif
   input  logic [DATA_WIDTH-1:0]  in_data,
   output logic [WINDOW_BITS-1:0] pack_window,
   output logic                   win_valid,
   output logic                   frame_end
);

   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
   localparam logic [COL_W-1:0] COL_EDGE = COL_W'(4);
   localparam logic [ROW_W-1:0] ROW_EDGE = ROW_W'(4);

   logic [COL_W-1:0]      r_col;
   logic [ROW_W-1:0]      r_row;
   logic [COL_W-1:0]      w_col;
   logic [ROW_W-1:0]      w_row;
   logic                  w_sof;
   logic [DATA_WIDTH-1:0] r_line [4][IMG_W];
   logic [DATA_WIDTH-1:0] w_tap [4];
   logic [DATA_WIDTH-1:0] w_new_col [5];
   logic [DATA_WIDTH-1:0] r_win [5][5];
   logic                  r_win_valid;
   logic                  r_frame_end;

`ifdef WINDOW_SOF_EN
   assign w_sof = in_valid & in_sof;
`else
   assign w_sof = 1'b0;
`endif

   // Position of the pixel being accepted; a start-of-frame marker forces (0,0).
   always_comb begin
      w_col = r_col;
      w_row = r_row;
      if (w_sof) begin
         w_col = {COL_W{1'b0}};
         w_row = {ROW_W{1'b0}};
      end else begin
         w_col = r_col;
         w_row = r_row;
      end
   end

   // Incoming window column: line k holds row-1-k, so the oldest line goes on top.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         w_tap[k] = r_line[k][w_col];
      end
      w_new_col[0] = w_tap[3];
      w_new_col[1] = w_tap[2];
      w_new_col[2] = w_tap[1];
      w_new_col[3] = w_tap[0];
      w_new_col[4] = in_data;
   end

   // Line buffers cascade one line down at the current column; contents are never cleared.
   always_ff @(posedge clk) begin
      if (in_valid) begin
         r_line[0][w_col] <= in_data;
         for (int k = 1; k < 4; k++) begin
            r_line[k][w_col] <= r_line[k-1][w_col];
         end
      end
   end

   // Column/row counters of the next pixel to accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_col <= {COL_W{1'b0}};
         r_row <= {ROW_W{1'b0}};
      end else if (in_valid) begin
         if (w_col == COL_LAST) begin
            r_col <= {COL_W{1'b0}};
            r_row <= (w_row == ROW_LAST) ? {ROW_W{1'b0}} : w_row + ROW_W'(1);
         end else begin
            r_col <= w_col + COL_W'(1);
            r_row <= w_row;
         end
      end
   end

   // 5x5 window: every row shifts left, new column enters on the right.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
               r_win[r][c] <= {DATA_WIDTH{1'b0}};
            end
         end
      end else if (in_valid) begin
         for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) begin
               r_win[r][c] <= r_win[r][c+1];
            end
            r_win[r][4] <= w_new_col[r];
         end
      end
   end

   // Window-valid and frame-end pulses; a window is whole only once row and col reach 4.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_win_valid <= 1'b0;
         r_frame_end <= 1'b0;
      end else begin
         r_win_valid <= in_valid && (w_row >= ROW_EDGE) && (w_col >= COL_EDGE);
         r_frame_end <= in_valid && (w_row == ROW_LAST) && (w_col == COL_LAST);
      end
   end

   // Element idx = r*5 + c, top-left oldest, bottom-right newest.
   always_comb begin
      pack_window = {WINDOW_BITS{1'b0}};
      for (int idx = 0; idx < WINDOW_S; idx++) begin
         pack_window[idx*DATA_WIDTH +: DATA_WIDTH] = r_win[idx/5][idx%5];
      end
   end

   assign win_valid = r_win_valid;
   assign frame_end = r_frame_end;

endmodule
